bp_mc_bridge_trace_monitor: RTL and testbench

BP_MC_BRIDGE_TRACE_MONITOR -- requirements
Module: bp_mc_bridge_trace_monitor

---
 rtl/bp_mc_trace_pkg.sv | 24 ++
 rtl/bp_mc_trace_chan_fifo.sv | 50 +++++
 rtl/bp_mc_bridge_trace_monitor.sv | 136 +++++++++++++
 tb/tb_bp_mc_bridge_trace_monitor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_mc_trace_pkg.sv
// Shared types and helpers for the memory-controller bridge trace monitor.
`ifndef BP_MC_TRACE_REC_W
`define BP_MC_TRACE_REC_W(ts_w, n_chan, d_w) ((ts_w) + $clog2(n_chan) + (d_w))
`endif

package bp_mc_trace_pkg;

    localparam int trace_ts_width_gp   = 32;
    localparam int trace_num_chan_gp   = 8;
    localparam int trace_data_width_gp = 64;

    // Record layout at the default configuration: {timestamp, channel id, payload}
    typedef struct packed {
        logic [trace_ts_width_gp-1:0]          ts;
        logic [$clog2(trace_num_chan_gp)-1:0]  id;
        logic [trace_data_width_gp-1:0]        data;
    } bp_mc_trace_rec_s;

    // Channels 2k (request) and 2k+1 (response) form pair k
    function automatic int unsigned pair_idx(input int unsigned chan);
        return chan >> 1;
    endfunction

endpackage

// File: rtl/bp_mc_trace_chan_fifo.sv
// Per-channel capture FIFO; a write that finds the FIFO full is dropped and flagged.
module bp_mc_trace_chan_fifo #(
    parameter int els_p   = 4,
    parameter int width_p = 99
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic               yumi_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               drop_o
);

    localparam int ptr_w_lp = $clog2(els_p);

    logic [width_p-1:0]  mem [els_p];
    logic [ptr_w_lp:0]   wptr_r, rptr_r;
    logic                enq, deq;

    // Extra pointer bit distinguishes full from empty
    assign empty_o = (wptr_r == rptr_r);
    assign full_o  = (wptr_r[ptr_w_lp] != rptr_r[ptr_w_lp])
                  && (wptr_r[ptr_w_lp-1:0] == rptr_r[ptr_w_lp-1:0]);
    assign enq     = v_i & ~full_o & ~clear_i;
    assign deq     = yumi_i & ~empty_o & ~clear_i;
    assign drop_o  = v_i & full_o & ~clear_i;
    assign data_o  = mem[rptr_r[ptr_w_lp-1:0]];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else if (clear_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (enq) wptr_r <= wptr_r + (ptr_w_lp+1)'(1);
            if (deq) rptr_r <= rptr_r + (ptr_w_lp+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr_r[ptr_w_lp-1:0]] <= data_i;
    end

endmodule

// File: rtl/bp_mc_bridge_trace_monitor.sv
// Handshake trace monitor: per-channel capture FIFOs, round-robin record output,
// event/drop counters and request/response outstanding tracking per channel pair.
module bp_mc_bridge_trace_monitor
    import bp_mc_trace_pkg::*;
#(
    parameter int num_chan_p   = 8,
    parameter int data_width_p = 64,
    parameter int fifo_els_p   = 4,
    parameter int ts_width_p   = 32,
    parameter int ctr_width_p  = 32,
    localparam int id_width_lp  = $clog2(num_chan_p),
    localparam int rec_width_lp = `BP_MC_TRACE_REC_W(ts_width_p, num_chan_p, data_width_p)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 trace_en_i,
    input  logic                                 clear_i,
    input  logic [num_chan_p-1:0]                chan_v_i,
    input  logic [num_chan_p-1:0]                chan_ready_i,
    input  logic [num_chan_p*data_width_p-1:0]   chan_data_i,
    output logic                                 trace_v_o,
    output logic [rec_width_lp-1:0]              trace_data_o,
    input  logic                                 trace_yumi_i,
    input  logic [id_width_lp-1:0]               ctr_sel_i,
    output logic [ctr_width_p-1:0]               evt_cnt_o,
    output logic [ctr_width_p-1:0]               drop_cnt_o,
    output logic [num_chan_p/2*ctr_width_p-1:0]  outstanding_o,
    output logic                                 overflow_o,
    output logic                                 protocol_err_o
);

    logic [ts_width_p-1:0]                         ts_r;
    logic [num_chan_p-1:0]                         fire, drop, full, empty, pop;
    logic [num_chan_p-1:0][rec_width_lp-1:0]       rec_in, rec_out;
    logic [num_chan_p-1:0][ctr_width_p-1:0]        evt_cnt_r, drop_cnt_r;
    logic [num_chan_p/2-1:0][ctr_width_p-1:0]      out_cnt_r;
    logic [id_width_lp-1:0]                        ptr_r, gnt_r, gnt, rr_pick;
    logic                                          lock_r, deq, rr_found;
    int                                            rr_idx;

    assign fire = {num_chan_p{trace_en_i}} & chan_v_i & chan_ready_i;

    for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
        assign rec_in[c] = {ts_r, id_width_lp'(c), chan_data_i[c*data_width_p +: data_width_p]};
        assign pop[c]    = deq && (gnt == id_width_lp'(c));

        bp_mc_trace_chan_fifo #(
            .els_p   (fifo_els_p),
            .width_p (rec_width_lp)
        ) fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .clear_i (clear_i),
            .v_i     (fire[c]),
            .data_i  (rec_in[c]),
            .yumi_i  (pop[c]),
            .data_o  (rec_out[c]),
            .full_o  (full[c]),
            .empty_o (empty[c]),
            .drop_o  (drop[c])
        );
    end

    // First non-empty FIFO at or after the priority pointer
    always_comb begin
        rr_pick  = ptr_r;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int i = 0; i < num_chan_p; i++) begin
            rr_idx = (int'(ptr_r) + i) % num_chan_p;
            if (!rr_found && !empty[rr_idx]) begin
                rr_pick  = id_width_lp'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end

    // A presented record stays granted until the consumer takes it
    assign gnt          = lock_r ? gnt_r : rr_pick;
    assign trace_v_o    = ~&empty;
    assign deq          = trace_v_o & trace_yumi_i;
    assign trace_data_o = rec_out[gnt];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ts_r           <= '0;
            ptr_r          <= '0;
            gnt_r          <= '0;
            lock_r         <= 1'b0;
            evt_cnt_r      <= '0;
            drop_cnt_r     <= '0;
            out_cnt_r      <= '0;
            overflow_o     <= 1'b0;
            protocol_err_o <= 1'b0;
        end else if (clear_i) begin
            ts_r           <= '0;
            ptr_r          <= '0;
            gnt_r          <= '0;
            lock_r         <= 1'b0;
            evt_cnt_r      <= '0;
            drop_cnt_r     <= '0;
            out_cnt_r      <= '0;
            overflow_o     <= 1'b0;
            protocol_err_o <= 1'b0;
        end else begin
            if (trace_en_i) ts_r <= ts_r + ts_width_p'(1);
            lock_r <= trace_v_o & ~trace_yumi_i;
            gnt_r  <= gnt;
            if (deq) ptr_r <= (gnt == id_width_lp'(num_chan_p-1)) ? '0 : gnt + id_width_lp'(1);
            if (|drop || |(fire & full)) overflow_o <= 1'b1;
            for (int c = 0; c < num_chan_p; c++) begin
                if (fire[c] && !(&evt_cnt_r[c]))  evt_cnt_r[c]  <= evt_cnt_r[c] + ctr_width_p'(1);
                if (drop[c] && !(&drop_cnt_r[c])) drop_cnt_r[c] <= drop_cnt_r[c] + ctr_width_p'(1);
            end
            for (int k = 0; k < num_chan_p/2; k++) begin
                if (fire[2*k] && !fire[2*k+1]) begin
                    if (!(&out_cnt_r[k])) out_cnt_r[k] <= out_cnt_r[k] + ctr_width_p'(1);
                end else if (fire[2*k+1] && !fire[2*k]) begin
                    if (out_cnt_r[k] == '0) protocol_err_o <= 1'b1;
                    else                    out_cnt_r[k]   <= out_cnt_r[k] - ctr_width_p'(1);
                end
            end
        end
    end

    assign outstanding_o = out_cnt_r;

    if (num_chan_p == (1 << id_width_lp)) begin : g_sel_full
        assign evt_cnt_o  = evt_cnt_r[ctr_sel_i];
        assign drop_cnt_o = drop_cnt_r[ctr_sel_i];
    end else begin : g_sel_chk
        assign evt_cnt_o  = (int'(ctr_sel_i) < num_chan_p) ? evt_cnt_r[ctr_sel_i]  : '0;
        assign drop_cnt_o = (int'(ctr_sel_i) < num_chan_p) ? drop_cnt_r[ctr_sel_i] : '0;
    end

endmodule

// File: tb/tb_bp_mc_bridge_trace_monitor.sv
// Scoreboard bench: stimulus queues expected records, a monitor checks each accepted record.
module tb_bp_mc_bridge_trace_monitor;
    import bp_mc_trace_pkg::*;

    localparam int NC = 8, DW = 64, TW = 32, CW = 32, IW = 3, RW = TW + IW + DW;

    logic              clk_i = 1'b0;
    logic              reset_i, trace_en_i, clear_i, trace_yumi_i;
    logic [NC-1:0]     chan_v_i, chan_ready_i;
    logic [NC*DW-1:0]  chan_data_i;
    logic              trace_v_o;
    logic [RW-1:0]     trace_data_o;
    logic [IW-1:0]     ctr_sel_i;
    logic [CW-1:0]     evt_cnt_o, drop_cnt_o;
    logic [NC/2*CW-1:0] outstanding_o;
    logic              overflow_o, protocol_err_o;

    int            nchk = 0, nerr = 0;
    logic [RW-1:0] exp_q[$];
    logic [TW-1:0] tsm;
    logic [RW-1:0] e5;

    always #5 clk_i = ~clk_i;

    bp_mc_bridge_trace_monitor #(
        .num_chan_p(NC), .data_width_p(DW), .fifo_els_p(4), .ts_width_p(TW), .ctr_width_p(CW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .trace_en_i(trace_en_i), .clear_i(clear_i),
        .chan_v_i(chan_v_i), .chan_ready_i(chan_ready_i), .chan_data_i(chan_data_i),
        .trace_v_o(trace_v_o), .trace_data_o(trace_data_o), .trace_yumi_i(trace_yumi_i),
        .ctr_sel_i(ctr_sel_i), .evt_cnt_o(evt_cnt_o), .drop_cnt_o(drop_cnt_o),
        .outstanding_o(outstanding_o), .overflow_o(overflow_o), .protocol_err_o(protocol_err_o)
    );

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chkc(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    // Monitor: every accepted record must match the head of the scoreboard
    always @(negedge clk_i) begin : mon
        logic [RW-1:0] e;
        if (reset_i === 1'b1 && trace_v_o === 1'b1 && trace_yumi_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_record: got %0h want none", trace_data_o);
            end else begin
                e = exp_q.pop_front();
                chk("record", trace_data_o, e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        if (!reset_i || clear_i) tsm = '0;
        else if (trace_en_i)     tsm = tsm + 1;
        #1;
    endtask

    task automatic drive(input logic [NC-1:0] v, input logic [NC-1:0] r,
                         input logic [DW-1:0] base, input logic [NC-1:0] keep);
        chan_v_i     = v;
        chan_ready_i = r;
        for (int c = 0; c < NC; c++) begin
            chan_data_i[c*DW +: DW] = base + DW'(c);
            if (keep[c]) exp_q.push_back({tsm, IW'(c), base + DW'(c)});
        end
        cyc();
        chan_v_i     = '0;
        chan_ready_i = '0;
    endtask

    task automatic cnt(input int ch, input logic [CW-1:0] ev, input logic [CW-1:0] dr);
        ctr_sel_i = IW'(ch);
        #1;
        chkc($sformatf("evt_cnt[%0d]", ch), evt_cnt_o, ev);
        chkc($sformatf("drop_cnt[%0d]", ch), drop_cnt_o, dr);
    endtask

    task automatic outs(input int ch, input logic [CW-1:0] exp);
        chkc($sformatf("outstanding[%0d]", pair_idx(ch)), outstanding_o[pair_idx(ch)*CW +: CW], exp);
    endtask

    task automatic clr();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain();
        int n = 0;
        trace_yumi_i = 1'b1;
        while (trace_v_o && n < 40) begin
            cyc();
            n++;
        end
        nchk++;
        if (trace_v_o !== 1'b0 || exp_q.size() != 0) begin
            nerr++;
            $display("FAIL drain: trace_v_o=%0b pending=%0d want 0 and 0", trace_v_o, exp_q.size());
        end
    endtask

    initial begin
        reset_i = 1'b0; trace_en_i = 1'b0; clear_i = 1'b0; trace_yumi_i = 1'b0;
        chan_v_i = '0; chan_ready_i = '0; chan_data_i = '0; ctr_sel_i = '0; tsm = '0;
        repeat (3) cyc();
        chk1("rst_trace_v", trace_v_o, 1'b0);
        chk1("rst_overflow", overflow_o, 1'b0);
        chk1("rst_proto", protocol_err_o, 1'b0);
        cnt(0, 0, 0);
        outs(0, 0);

        // Single capture at timestamp 10
        reset_i = 1'b1; trace_en_i = 1'b1; trace_yumi_i = 1'b1;
        repeat (10) cyc();
        drive(8'h08, 8'h08, 64'hDEAA, 8'h08);
        @(negedge clk_i);
        chk1("single_v", trace_v_o, 1'b1);
        chk("single_rec", trace_data_o, {32'd10, 3'd3, 64'hDEAD});
        cyc();
        chk1("single_empty", trace_v_o, 1'b0);
        cnt(3, 1, 0);
        drive(8'h04, 8'h00, 64'h0, 8'h00);
        cnt(2, 0, 0);

        // Overflow on ch0, then a fire on a full FIFO that drains the same cycle
        trace_yumi_i = 1'b0;
        clr();
        for (int i = 0; i < 6; i++) drive(8'h01, 8'h01, 64'h100 + 64'(i * 16), (i < 4) ? 8'h01 : 8'h00);
        cnt(0, 6, 2);
        chk1("overflow_set", overflow_o, 1'b1);
        trace_yumi_i = 1'b1;
        drive(8'h01, 8'h01, 64'h1FF0, 8'h00);
        cnt(0, 7, 3);
        drain();

        // Round-robin order and grant lock
        clr();
        drive(8'h52, 8'h52, 64'h4000, 8'h52);
        drain();
        trace_yumi_i = 1'b0;
        e5 = {tsm, 3'd5, 64'h5005};
        drive(8'h20, 8'h20, 64'h5000, 8'h20);
        drive(8'h01, 8'h01, 64'h6000, 8'h01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk($sformatf("hold_data_%0d", i), trace_data_o, e5);
            if (i < 2) cyc();
        end
        cyc();
        drain();

        // Pair 0 outstanding tracking
        trace_yumi_i = 1'b0;
        clr();
        repeat (3) drive(8'h01, 8'h01, 64'h0, 8'h00);
        outs(0, 3);
        drive(8'h03, 8'h03, 64'h0, 8'h00);
        outs(0, 3);
        drive(8'h01, 8'h00, 64'h0, 8'h00);
        outs(0, 3);
        cnt(0, 4, 0);
        repeat (3) drive(8'h02, 8'h02, 64'h0, 8'h00);
        outs(0, 0);
        chk1("proto_clean", protocol_err_o, 1'b0);
        drive(8'h02, 8'h02, 64'h0, 8'h00);
        outs(0, 0);
        outs(2, 0);
        chk1("proto_set", protocol_err_o, 1'b1);
        cnt(1, 5, 1);
        clr();

        // Disabled tracing freezes capture but still drains
        trace_en_i = 1'b1;
        drive(8'h04, 8'h04, 64'h7000, 8'h04);
        drive(8'h04, 8'h04, 64'h7100, 8'h04);
        trace_en_i = 1'b0;
        repeat (5) drive(8'h04, 8'h04, 64'h7700, 8'h00);
        cnt(2, 2, 0);
        chk1("frozen_v", trace_v_o, 1'b1);
        drain();
        trace_en_i = 1'b1;
        drive(8'h04, 8'h04, 64'h7800, 8'h04);
        drain();

        // Reset mid-drain, then first fire after release
        trace_yumi_i = 1'b0;
        clr();
        drive(8'h07, 8'h07, 64'h9000, 8'h07);
        outs(2, 1);
        trace_yumi_i = 1'b1;
        cyc();
        #2;
        reset_i = 1'b0;
        exp_q.delete();
        #1;
        chk1("reset_v", trace_v_o, 1'b0);
        cnt(2, 0, 0);
        outs(2, 0);
        cyc();
        reset_i = 1'b1;
        drive(8'h80, 8'h80, 64'hA000, 8'h80);
        drain();

        // Clear after traffic, with a fire in the clear cycle
        trace_yumi_i = 1'b0;
        drive(8'h02, 8'h02, 64'h0, 8'h00);
        repeat (5) drive(8'h10, 8'h10, 64'hB000, 8'h00);
        chk1("pre_clr_ovf", overflow_o, 1'b1);
        chk1("pre_clr_proto", protocol_err_o, 1'b1);
        chan_v_i = 8'h10; chan_ready_i = 8'h10; clear_i = 1'b1;
        cyc();
        clear_i = 1'b0; chan_v_i = '0; chan_ready_i = '0;
        exp_q.delete();
        chk1("clr_v", trace_v_o, 1'b0);
        chk1("clr_ovf", overflow_o, 1'b0);
        chk1("clr_proto", protocol_err_o, 1'b0);
        cnt(4, 0, 0);
        cnt(1, 0, 0);
        trace_yumi_i = 1'b1;
        drive(8'h08, 8'h08, 64'hC000, 8'h08);
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        nerr++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $fatal(1, "timeout");
    end

endmodule
